// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: captures rx_done bytes,
// exposes head word, occupancy, full/empty and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  output logic [DBIT-1:0]   r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic              do_wr;
  logic              do_rd;
  logic              drop;

  // Flags come straight from the count register, so wr never reaches full/empty combinationally.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign r_data   = empty ? '0 : mem[r_ptr];

  // A write into a full FIFO is only accepted when a pop frees the head slot.
  assign do_wr = wr & (~full | rd);
  assign do_rd = rd & ~empty;
  assign drop  = wr & full & ~rd;

  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem[w_ptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + PTR_ONE;
      if (do_rd) r_ptr <= r_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      // Set beats clear when a drop and clr_ovf coincide.
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer placed directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle done pulse and holds it until the host/bus side pops it.
- Provides first-word-fall-through read, occupancy count, full/empty flags and a sticky overflow flag so that bursts arriving faster than the consumer reads are absorbed or reported.

Parameters:
DBIT, 8, data word width; must match the receiver's data-bit count.
ADDR_W, 4, address width; depth = 2**ADDR_W entries (16 by default).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
wr  input  1  write strobe; connect to receiver rx_done_tick (one-cycle pulse).
w_data  input  DBIT  write data; connect to receiver rx_dout; sampled when wr=1.
rd  input  1  pop strobe from consumer; one entry removed per cycle rd=1 and empty=0.
r_data  output  DBIT  head-of-queue word (FWFT); valid whenever empty=0.
empty  output  1  1 when count==0.
full  output  1  1 when count==2**ADDR_W.
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
overflow  output  1  sticky; set when a write is dropped because FIFO is full.
clr_ovf  input  1  clears overflow (single-cycle pulse or level).

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge), taking priority over all other inputs:
  - w_ptr=0, r_ptr=0, count=0, empty=1, full=0, overflow=0.
  - Storage array is not reset.
  - A reset mid-burst discards all stored words.
- Storage:
  - 2**ADDR_W x DBIT array; w_ptr and r_ptr are ADDR_W bits wide.
  - Pointers wrap from 2**ADDR_W-1 to 0 with natural modulo arithmetic.
  - full and empty are derived from count, never from pointer equality alone.
- Read data:
  - r_data = mem[r_ptr] combinationally when empty=0.
  - r_data is forced to 0 when empty=1, including immediately after reset.
- Write latency: a word written at edge N appears on r_data after edge N, visible in cycle N+1, if the FIFO was empty. No bypass in the same cycle.
- Operation per edge, given rst=0. Let do_wr = wr & (~full | rd) and do_rd = rd & ~empty.
  - do_wr: mem[w_ptr] <= w_data; w_ptr <= w_ptr+1.
  - do_rd: r_ptr <= r_ptr+1.
  - count <= count + do_wr - do_rd.
- Boundary cases:
  - rd with empty=1: ignored; no pointer or count change, no error flag.
  - wr with full=1 and rd=0: word dropped, pointers unchanged, overflow <= 1.
  - wr and rd with full=1: both occur, count stays at max, no overflow.
  - wr and rd with empty=1: only the write occurs; count becomes 1.
  - wr and rd otherwise: both occur, count unchanged.
- Overflow flag:
  - Set by a dropped write; cleared by clr_ovf.
  - If a dropped write and clr_ovf occur in the same cycle, set wins and overflow=1.
  - Overflow does not block further writes once space frees.
- Flag timing: empty, full and count are registered-consistent, i.e. valid the cycle after the edge that changed them. No combinational path from wr to full/empty.
- wr is assumed to be single-cycle per byte. A held wr writes every cycle, and the block does not filter it.

Test Plan:
- Reset then idle 5 cycles -> empty=1, full=0, count=0, overflow=0, r_data=0.
- Write 0xA5, 0x3C, 0x7E with one cycle each, then pop 3 -> r_data sequence 0xA5, 0x3C, 0x7E; count 3->2->1->0; empty=1 after last pop; extra rd while empty leaves count=0.
- Write 16 bytes 0x00..0x0F -> full=1, count=16. 17th write 0xFF -> dropped, overflow=1, count=16. Pop all 16 -> 0x00..0x0F in order, no 0xFF.
- Fill to 16, then wr+rd together for 20 cycles with new data -> count stays 16, overflow stays 0, read order preserved across pointer wrap.
- With empty, assert wr=1 (0x55) and rd=1 same cycle -> count=1, r_data=0x55 next cycle. With count=5, wr+rd together -> count remains 5.
- Overflow set, then clr_ovf coinciding with another dropped write -> overflow stays 1. clr_ovf alone next cycle -> 0. Assert rst with count=7 -> count=0, empty=1, overflow=0 after the edge.
